// File: rtl/display_scan_mux.sv
// Time-multiplexed 7-segment scan driver: one shared segment bus,
// one-hot anode select, programmable slot length and dead-time blanking.
module display_scan_mux #(
  parameter int NUM_DIGITS       = 4,
  parameter int SEG_WIDTH        = 7,
  parameter int REFRESH_DIV      = 50000,
  parameter int BLANK_CYCLES     = 1000,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CW = $clog2(REFRESH_DIV)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_DIGITS*SEG_WIDTH-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]           digit_en,
  input  logic                            freeze,
  output logic [SEG_WIDTH-1:0]            seg_out,
  output logic [NUM_DIGITS-1:0]           an_out,
  output logic [IW-1:0]                   digit_idx,
  output logic                            frame_tick
);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [SEG_WIDTH-1:0]  seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  ft_q, ft_d;

  logic [IW-1:0] nxt_idx;
  logic          found;
  logic          any_en;
  logic          wrap;
  logic          active;

  // Round-robin search starting after idx, idx itself last
  always_comb begin
    nxt_idx = idx_q;
    found   = 1'b0;
    for (int k = 1; k <= NUM_DIGITS; k++) begin
      if (!found && digit_en[(int'(idx_q) + k) % NUM_DIGITS]) begin
        found   = 1'b1;
        nxt_idx = IW'((int'(idx_q) + k) % NUM_DIGITS);
      end
    end
  end

  always_comb begin
    any_en = |digit_en;
    wrap   = (cnt_q == CW'(REFRESH_DIV - 1));
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    ft_d   = 1'b0;
    if (!freeze) begin
      if (wrap) begin
        cnt_d = '0;
        idx_d = nxt_idx;
        ft_d  = any_en && (nxt_idx <= idx_q);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    active = digit_en[idx_q]
          && (int'(cnt_q) >= BLANK_CYCLES)
          && !reset;
    an_d  = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
    seg_d = '0;
    if (active) begin
      an_d[idx_q] = ~ANODE_ACTIVE_LOW;
      seg_d       = seg_in[int'(idx_q)*SEG_WIDTH +: SEG_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      seg_q <= '0;
      an_q  <= {NUM_DIGITS{ANODE_ACTIVE_LOW}};
      ft_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
      ft_q  <= ft_d;
    end
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign digit_idx  = idx_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: directed scenarios plus random stimulus,
// all checked cycle by cycle against a behavioural scan model.
module tb_display_scan_mux;

  localparam int ND = 4;
  localparam int SW = 7;
  localparam int RD = 4;
  localparam int BL = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [27:0]   seg_in;
  logic [3:0]    digit_en;
  logic          freeze;
  logic [6:0]    seg_out;
  logic [3:0]    an_out;
  logic [1:0]    digit_idx;
  logic          frame_tick;

  int n_chk = 0;
  int n_err = 0;
  int ft_cnt = 0;

  int         m_cnt, m_idx;
  logic [6:0] e_seg;
  logic [3:0] e_an;
  logic       e_ft;

  display_scan_mux #(
    .NUM_DIGITS(ND), .SEG_WIDTH(SW), .REFRESH_DIV(RD),
    .BLANK_CYCLES(BL), .ANODE_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in),
    .digit_en(digit_en), .freeze(freeze),
    .seg_out(seg_out), .an_out(an_out),
    .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  // Scan behaviour at slot level: outputs from pre-edge state
  task automatic model_step();
    logic act;
    int   nxt;
    if (reset) begin
      m_cnt = 0; m_idx = 0;
      e_seg = 0; e_an = 4'hF; e_ft = 0;
    end else begin
      act   = digit_en[m_idx] && (m_cnt >= BL);
      e_an  = act ? 4'(~(1 << m_idx)) : 4'hF;
      e_seg = act ? 7'((seg_in >> (SW * m_idx)) & 28'h7F) : 7'h00;
      e_ft  = 0;
      if (!freeze) begin
        if (m_cnt == RD - 1) begin
          m_cnt = 0;
          if (digit_en != 0) begin
            nxt = m_idx;
            for (int k = ND; k >= 1; k--)
              if (digit_en[(m_idx + k) % ND]) nxt = (m_idx + k) % ND;
            e_ft  = (nxt <= m_idx);
            m_idx = nxt;
          end
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("seg_out", 32'(seg_out), 32'(e_seg));
    chk("an_out", 32'(an_out), 32'(e_an));
    chk("digit_idx", 32'(digit_idx), 32'(m_idx));
    chk("frame_tick", 32'(frame_tick), 32'(e_ft));
    chk("onehot", 32'($countones(~an_out) <= 1), 32'd1);
    if (frame_tick) ft_cnt++;
  endtask

  task automatic wait_slot(input int ti, input int tc);
    int n = 0;
    while (!(m_idx == ti && m_cnt == tc) && n < 64) begin
      tick();
      n++;
    end
    chk("wait_slot", 32'(n < 64), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    freeze = 1'b0;
    digit_en = 4'hF;
    seg_in = 28'($urandom);
    m_cnt = 0; m_idx = 0;
    for (int i = 0; i < 3; i++) begin
      seg_in = 28'($urandom);
      tick();
    end
    chk("rst_seg", 32'(seg_out), 32'h00);
    chk("rst_an", 32'(an_out), 32'hF);
    chk("rst_idx", 32'(digit_idx), 32'd0);
    chk("rst_ft", 32'(frame_tick), 32'd0);

    // Full scan
    reset = 1'b0;
    seg_in = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    ft_cnt = 0;
    tick();
    chk("first_blank", 32'(an_out), 32'hF);
    tick();
    chk("first_an", 32'(an_out), 32'hE);
    chk("first_seg", 32'(seg_out), 32'h3F);
    for (int i = 2; i < 32; i++) tick();
    chk("scan_ft", 32'(ft_cnt), 32'd2);

    // Skip
    digit_en = 4'b0101;
    ft_cnt = 0;
    for (int i = 0; i < 32; i++) tick();
    chk("skip_ft", 32'(ft_cnt), 32'd4);

    // None enabled
    digit_en = 4'b0000;
    ft_cnt = 0;
    for (int i = 0; i < 20; i++) tick();
    chk("none_ft", 32'(ft_cnt), 32'd0);
    chk("none_an", 32'(an_out), 32'hF);

    // Single enabled
    digit_en = 4'b1000;
    for (int i = 0; i < 16; i++) tick();
    chk("single_idx", 32'(digit_idx), 32'd3);
    ft_cnt = 0;
    for (int i = 0; i < 16; i++) tick();
    chk("single_ft", 32'(ft_cnt), 32'd4);

    // Freeze on digit 1 at cnt=2
    digit_en = 4'hF;
    wait_slot(1, 2);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    seg_in[13:7] = 7'h7F;
    tick();
    chk("frz_seg", 32'(seg_out), 32'h7F);
    chk("frz_an", 32'(an_out), 32'hD);
    for (int i = 0; i < 6; i++) tick();
    chk("frz_idx", 32'(digit_idx), 32'd1);
    freeze = 1'b0;
    tick();
    tick();
    chk("frz_resume", 32'(digit_idx), 32'd2);

    // Mid-slot disable, then reset mid-slot
    wait_slot(2, 2);
    digit_en[2] = 1'b0;
    tick();
    chk("dis_an", 32'(an_out), 32'hF);
    wait_slot(3, 1);
    reset = 1'b1;
    tick();
    chk("mrst_an", 32'(an_out), 32'hF);
    chk("mrst_seg", 32'(seg_out), 32'h00);
    chk("mrst_idx", 32'(digit_idx), 32'd0);
    reset = 1'b0;

    // Random
    for (int i = 0; i < 3000; i++) begin
      seg_in = 28'($urandom);
      if ($urandom_range(0, 29) == 0) digit_en = 4'($urandom);
      freeze = ($urandom_range(0, 9) == 0);
      reset  = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
